fp32_mant_sum_pipe: RTL

FP32_MANT_SUM_PIPE -- requirements
Module: fp32_mant_sum_pipe

---
 rtl/fp32_mant_sum_pipe.sv | 93 +++++++++
 1 files changed

// File: rtl/fp32_mant_sum_pipe.sv
// fp32_mant_sum_pipe: 3-stage signed adder tree for eight aligned FP32 mantissas, with special-case flags
module fp32_mant_sum_pipe #(
    parameter int NUM_INPUTS = 8,
    parameter int SUM_WIDTH  = 31
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_INPUTS-1:0]       signs,
    input  logic [7:0]                  max_exponent,
    input  logic [NUM_INPUTS*27-1:0]    aligned_mantissas_flat,
    input  logic [NUM_INPUTS-1:0]       is_infs,
    input  logic [NUM_INPUTS-1:0]       is_nans,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        sum_sign,
    output logic [29:0]                 sum_mag,
    output logic [7:0]                  sum_exponent,
    output logic                        res_is_nan,
    output logic                        res_is_inf,
    output logic                        res_inf_sign,
    output logic                        res_is_zero
);
    logic                 adv;
    logic                 s1_valid, s2_valid, s3_valid;
    logic [27:0]          op [NUM_INPUTS];
    logic [28:0]          s1_sum [NUM_INPUTS/2];
    logic [29:0]          s2_sum [NUM_INPUTS/4];
    logic [SUM_WIDTH-1:0] s3_sum;
    logic [7:0]           s1_exp, s2_exp, s3_exp;
    logic                 pos_inf, neg_inf, f_nan, f_inf, f_isg;
    logic                 s1_nan, s1_inf, s1_isg;
    logic                 s2_nan, s2_inf, s2_isg;
    logic                 s3_nan, s3_inf, s3_isg;
    logic [29:0]          s3_low, mag;

    assign adv      = !s3_valid || out_ready;
    assign in_ready = adv || rst;

    // Turn each magnitude into 28-bit two's complement according to its sign
    always_comb begin
        for (int k = 0; k < NUM_INPUTS; k++)
            op[k] = signs[k] ? -{1'b0, aligned_mantissas_flat[27*k +: 27]} : {1'b0, aligned_mantissas_flat[27*k +: 27]};
    end

    assign pos_inf = |(is_infs & ~signs);
    assign neg_inf = |(is_infs & signs);
    assign f_nan   = |is_nans || (pos_inf && neg_inf);
    assign f_inf   = !f_nan && |is_infs;
    assign f_isg   = f_inf && neg_inf;

    // Stage valid bits: shift together on advance, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    // Adder tree and side-band data; all stages hold together when stalled
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < NUM_INPUTS/2; k++)
                s1_sum[k] <= {op[2*k][27], op[2*k]} + {op[2*k+1][27], op[2*k+1]};
            for (int k = 0; k < NUM_INPUTS/4; k++)
                s2_sum[k] <= {s1_sum[2*k][28], s1_sum[2*k]} + {s1_sum[2*k+1][28], s1_sum[2*k+1]};
            s3_sum <= {s2_sum[0][29], s2_sum[0]} + {s2_sum[1][29], s2_sum[1]};
            s1_exp <= max_exponent;
            s2_exp <= s1_exp;
            s3_exp <= s2_exp;
            {s1_nan, s1_inf, s1_isg} <= {f_nan, f_inf, f_isg};
            {s2_nan, s2_inf, s2_isg} <= {s1_nan, s1_inf, s1_isg};
            {s3_nan, s3_inf, s3_isg} <= {s2_nan, s2_inf, s2_isg};
        end
    end

    assign s3_low       = s3_sum[29:0];
    assign mag          = s3_sum[SUM_WIDTH-1] ? -s3_low : s3_low;
    assign out_valid    = s3_valid;
    assign sum_sign     = s3_valid && s3_sum[SUM_WIDTH-1];
    assign sum_mag      = s3_valid ? mag : '0;
    assign sum_exponent = s3_valid ? s3_exp : '0;
    assign res_is_nan   = s3_valid && s3_nan;
    assign res_is_inf   = s3_valid && s3_inf;
    assign res_inf_sign = s3_valid && s3_isg;
    assign res_is_zero  = s3_valid && (s3_sum == '0) && !s3_nan && !s3_inf;
endmodule
